// File: rtl/duv_mux_rr.sv
// duv_mux_rr: N-channel, W-bit registered selector with valid/ready handshakes,
// fixed-select or round-robin arbitration. Optional packet lock: DUV_MUX_PKT_LOCK_EN.

module duv_mux_rr_lane #(
  parameter int W    = 4,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            can_accept,
  input  logic            grant_vld,
  input  logic [SELW-1:0] grant,
  input  logic [W-1:0]    data,
  output logic            ready,
  output logic [W-1:0]    data_sel
);
  assign ready    = can_accept & grant_vld & (grant == SELW'(IDX));
  assign data_sel = ready ? data : '0;
endmodule

module duv_mux_rr #(
  parameter  int W    = 4,
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
`ifdef DUV_MUX_PKT_LOCK_EN
  input  logic [N-1:0]    in_last,
`endif
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  input  logic            out_ready
);

  logic [N-1:0][W-1:0] lane_data, lane_sel;
  logic [SELW-1:0]     ptr, grant;
  logic                grant_vld, can_accept, accept;
  logic [W-1:0]        mux_data;

  assign lane_data = in_data;
  // Gating with reset keeps in_ready low and blocks any accept in the reset cycle.
  assign can_accept = ~reset & (~out_valid | out_ready);
  assign accept     = can_accept & grant_vld;

`ifdef DUV_MUX_PKT_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;

  always_ff @(posedge clk) begin
    if (reset || !mode) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      locked  <= ~in_last[grant];
      lock_ch <= grant;
    end
  end
`endif

  always_comb begin
    logic [SELW-1:0] idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        grant     = sel;
        grant_vld = in_valid[sel];
      end
    end
`ifdef DUV_MUX_PKT_LOCK_EN
    else if (locked) begin
      grant     = lock_ch;
      grant_vld = in_valid[lock_ch];
    end
`endif
    else begin
      // Scan far-to-near so the channel closest after ptr is the last writer.
      for (int k = N; k >= 1; k--) begin
        idx = SELW'((int'(ptr) + k) % N);
        if (in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    duv_mux_rr_lane #(.W(W), .SELW(SELW), .IDX(i)) u_lane (
      .can_accept (can_accept),
      .grant_vld  (grant_vld),
      .grant      (grant),
      .data       (lane_data[i]),
      .ready      (in_ready[i]),
      .data_sel   (lane_sel[i])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) mux_data |= lane_sel[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_ch    <= grant;
      if (mode) ptr <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
